tmds_channel_decoder: RTL

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_channel_decoder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
//
// Purpose:
//   Recovers symbol alignment on one TMDS channel and decodes the aligned
//   10-bit symbols into pixel bytes and control bits. Alignment is found by
//   hunting through the ten possible bit offsets until a run of consecutive
//   control tokens is seen; once locked the offset is frozen and lock is only
//   dropped after a long stretch without any control token.
//
//   No valid/ready handshake: the block accepts one symbol per clk_pixel cycle
//   unconditionally and emits one decoded symbol per cycle.
//
//   Pipeline: tmds_in -> prev -> stage 1 (aligned symbol) -> stage 2 (outputs).
//   The aligned symbol is taken from {tmds_in, prev}, so at offset 0 it is the
//   word held in prev.
//
// Ports:
//   clk_pixel  in   1   pixel clock, one 10-bit symbol per cycle
//   resetn     in   1   asynchronous active-low reset
//   tmds_in    in  10   raw deserialized word, bit 0 received first
//   data       out  8   decoded pixel byte (0 for control symbols / unlocked)
//   c          out  2   decoded control bits {c1,c0}, held across data symbols
//   de         out  1   1 = data symbol, 0 = control symbol or unlocked
//   locked     out  1   alignment achieved (FSM is in LOCKED)
//   offset     out  4   current bit-slip offset, 0..9
// -----------------------------------------------------------------------------
module tmds_channel_decoder #(
    parameter int c_run     = 8,
    parameter int c_window  = 1024,
    parameter int c_timeout = 4096
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic [9:0] tmds_in,
    output logic [7:0] data,
    output logic [1:0] c,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int RUN_W = $clog2(c_run + 1);
    localparam int WIN_W = $clog2(c_window + 1);
    localparam int TMO_W = $clog2(c_timeout + 1);

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    // Registers
    logic [9:0]       r_prev;
    logic [9:0]       r_s1;
    logic [0:0]       r_state;
    logic [3:0]       r_offset;
    logic [RUN_W-1:0] r_run;
    logic [WIN_W-1:0] r_win;
    logic [TMO_W-1:0] r_tmo;
    logic [1:0]       r_flush;
    logic [7:0]       r_data;
    logic [1:0]       r_c;
    logic             r_de;

    // Combinational
    logic [19:0]      w_cat;
    logic [9:0]       w_aligned;
    logic             w_is_tok;
    logic [1:0]       w_tok_c;
    logic [7:0]       w_q;
    logic [7:0]       w_dec;
    logic [RUN_W-1:0] w_run_inc;
    logic [TMO_W-1:0] w_tmo_inc;
    logic [0:0]       w_state_nxt;
    logic [3:0]       w_offset_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [WIN_W-1:0] w_win_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic [1:0]       w_flush_nxt;

    assign w_cat = {tmds_in, r_prev};

    // Bit-slip select: symbol = w_cat[offset+9 : offset].
    always_comb begin
        w_aligned = w_cat[9:0];
        case (r_offset)
            4'd1:    w_aligned = w_cat[10:1];
            4'd2:    w_aligned = w_cat[11:2];
            4'd3:    w_aligned = w_cat[12:3];
            4'd4:    w_aligned = w_cat[13:4];
            4'd5:    w_aligned = w_cat[14:5];
            4'd6:    w_aligned = w_cat[15:6];
            4'd7:    w_aligned = w_cat[16:7];
            4'd8:    w_aligned = w_cat[17:8];
            4'd9:    w_aligned = w_cat[18:9];
            default: w_aligned = w_cat[9:0];
        endcase
    end

    // Control token recognition on stage 1.
    always_comb begin
        w_is_tok = 1'b1;
        w_tok_c  = 2'b00;
        case (r_s1)
            TOK_C00: w_tok_c = 2'b00;
            TOK_C01: w_tok_c = 2'b01;
            TOK_C10: w_tok_c = 2'b10;
            TOK_C11: w_tok_c = 2'b11;
            default: w_is_tok = 1'b0;
        endcase
    end

    // Data symbol decode: undo the optional inversion (bit 9), then the
    // XOR/XNOR transition chain selected by bit 8.
    always_comb begin
        w_q      = r_s1[9] ? ~r_s1[7:0] : r_s1[7:0];
        w_dec    = 8'h00;
        w_dec[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_s1[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    assign w_run_inc = r_run + RUN_W'(1);
    assign w_tmo_inc = r_tmo + TMO_W'(1);

    // Alignment FSM and its counters.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_run_nxt    = r_run;
        w_win_nxt    = r_win;
        w_tmo_nxt    = r_tmo;
        w_flush_nxt  = (r_flush != 2'd0) ? r_flush - 2'd1 : 2'd0;
        case (r_state)
            ST_HUNT: begin
                w_win_nxt = r_win + WIN_W'(1);
                // Symbols still in flight from the previous offset are ignored.
                if (r_flush == 2'd0) begin
                    w_run_nxt = w_is_tok ? w_run_inc : '0;
                end
                // Lock wins over window expiry when both happen together.
                if ((r_flush == 2'd0) && w_is_tok && (w_run_inc == RUN_W'(c_run))) begin
                    w_state_nxt = ST_LOCKED;
                    w_run_nxt   = '0;
                    w_win_nxt   = '0;
                    w_tmo_nxt   = '0;
                end else if (r_win == WIN_W'(c_window - 1)) begin
                    w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    w_run_nxt    = '0;
                    w_win_nxt    = '0;
                    w_flush_nxt  = 2'd2;
                end
            end
            ST_LOCKED: begin
                if (w_is_tok) begin
                    w_tmo_nxt = '0;
                end else if (w_tmo_inc == TMO_W'(c_timeout)) begin
                    // Lost lock: hunt again from the current offset.
                    w_state_nxt = ST_HUNT;
                    w_tmo_nxt   = '0;
                    w_run_nxt   = '0;
                    w_win_nxt   = '0;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r_prev   <= '0;
            r_s1     <= '0;
            r_state  <= ST_HUNT;
            r_offset <= '0;
            r_run    <= '0;
            r_win    <= '0;
            r_tmo    <= '0;
            r_flush  <= '0;
            r_data   <= '0;
            r_c      <= '0;
            r_de     <= 1'b0;
        end else begin
            r_prev   <= tmds_in;
            r_s1     <= w_aligned;
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_run    <= w_run_nxt;
            r_win    <= w_win_nxt;
            r_tmo    <= w_tmo_nxt;
            r_flush  <= w_flush_nxt;
            // Outputs are qualified with the next state so they always agree
            // with the locked flag registered on the same edge.
            if (w_state_nxt == ST_LOCKED) begin
                if (w_is_tok) begin
                    r_data <= 8'h00;
                    r_c    <= w_tok_c;
                    r_de   <= 1'b0;
                end else begin
                    r_data <= w_dec;
                    r_de   <= 1'b1;
                end
            end else begin
                r_data <= 8'h00;
                r_c    <= 2'b00;
                r_de   <= 1'b0;
            end
        end
    end

    assign data   = r_data;
    assign c      = r_c;
    assign de     = r_de;
    assign locked = (r_state == ST_LOCKED);
    assign offset = r_offset;

endmodule
